// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: fetches a block from IRAM word by word,
// stalls fetch while busy and writes the assembled block for one cycle.
module icache_refill_ctrl #(
    parameter int BLOCK_BITS = 128,
    parameter int PC_W       = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  fetch_en,
    input  logic [PC_W-1:0]       pc,
    input  logic                  hit,
    input  logic                  flush,
    output logic                  stall,
    output logic                  we,
    output logic [0:BLOCK_BITS-1] block_out,
    output logic [PC_W-1:0]       refill_addr,
    output logic                  refill_done,
    output logic                  mem_req,
    output logic [PC_W-1:0]       mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [0:31]           mem_rdata
);

    localparam int WORDS = BLOCK_BITS / 32;
    localparam int OFS   = $clog2(BLOCK_BITS / 8);
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [PC_W-1:0] OFS_MASK = PC_W'((1 << OFS) - 1);
    localparam logic [CW-1:0]   LAST     = CW'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        DRAIN
    } state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt;
    logic [PC_W-1:0]       addr_q;
    logic [0:BLOCK_BITS-1] buf_q;
    logic                  miss;
    logic                  start;
    logic                  store;
    logic                  bump;

    assign miss = fetch_en & ~hit & ~flush;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        start   = 1'b0;
        store   = 1'b0;
        bump    = 1'b0;
        unique case (state)
            IDLE: begin
                if (miss) begin
                    start   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt)    state_d = flush ? DRAIN : WAIT;
                else if (flush) state_d = IDLE;
            end
            WAIT: begin
                // a flush racing the data drops it; no read left outstanding
                if (mem_rvalid && flush) begin
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end else if (mem_rvalid) begin
                    store = 1'b1;
                    if (cnt == LAST) begin
                        state_d = WRITE;
                    end else begin
                        bump    = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            DRAIN: begin
                if (mem_rvalid) state_d = IDLE;
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt    <= '0;
            addr_q <= '0;
            buf_q  <= '0;
        end else begin
            if (start) begin
                addr_q <= pc & ~OFS_MASK;
                cnt    <= '0;
            end
            if (bump) cnt <= cnt + 1'b1;
            if (store) begin
                for (int i = 0; i < WORDS; i++) begin
                    if (cnt == CW'(i)) buf_q[32*i +: 32] <= mem_rdata;
                end
            end
        end
    end

    assign stall       = nrst & ((state != IDLE) | miss);
    assign mem_req     = (state == REQ);
    assign mem_addr    = addr_q + (PC_W'(cnt) << 2);
    assign we          = (state == WRITE);
    assign refill_done = we;
    assign block_out   = we ? buf_q : '0;
    assign refill_addr = addr_q;

endmodule
